reorder_buffer: RTL and testbench
=================================

# reorder_buffer

Circular reorder buffer for the out-of-order core. Allocates ROB tags at dispatch, records CDB writebacks, retires completed instructions in program order, and squashes wrong-path entries on branch misprediction. It is the producer of the allocation tag, writeback and commit signals consumed by the rename map table, and of the architectural write to the register file.

## Interface
- `ROB_SIZE`, 8: number of entries, power of two, ≥ 2.
- `ROB_TAG_LEN`, `$clog2(ROB_SIZE)+1`: tag width. Tag = index+1; tag 0 is reserved for "no producer / value in register file".

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low: state is cleared on a rising edge of `clock` while `reset`==0.
- `dispatch_en`  in  1  allocate one entry this cycle.
- `dispatch_rd`  in  5  destination register; 0 means no destination.
- `dispatch_is_branch`  in  1  entry is a conditional branch.
- `rob_entry_out`  out  ROB_TAG_LEN  tag the next allocation receives.
- `rob_full`  out  1  no free entry.
- `cdb_valid`  in  1  functional-unit result valid.
- `cdb_tag`  in  ROB_TAG_LEN  producing entry.
- `cdb_value`  in  32  result.
- `valid_wb`  out  1  writeback accepted into a live entry.
- `rd_wb`  out  5  destination of that entry.
- `rob_entry_wb`  out  ROB_TAG_LEN  equals `cdb_tag`.
- `commit`  out  1  head entry retires this cycle.
- `rd_commit`  out  5  retiring destination.
- `rob_entry_commit`  out  ROB_TAG_LEN  retiring tag.
- `commit_value`  out  32  retiring result, for the register-file write.
- `branch_determined`  in  1  the outstanding branch resolved this cycle.
- `branch_misprediction`  in  1  qualifies `branch_determined`.
- `branch_tag`  in  ROB_TAG_LEN  tag of the resolving branch.
- `branch_speculating`  out  1  an unresolved branch is in the ROB.

## Operation
- Per-entry state: valid, complete, rd, value, is_branch. Registered pointers: head, tail, count (0..ROB_SIZE), plus the branch-pending flag.
- Dispatch: if `dispatch_en && !rob_full`, write entry[tail] with valid=1, complete=0 and the dispatch fields. Advance tail modulo ROB_SIZE. Increment count. If `dispatch_is_branch`, set the branch-pending flag. If `rob_full`, `dispatch_en` is ignored.
- `rob_entry_out` = tail+1. `rob_full` = (count==ROB_SIZE). Both are functions of registered state only.
- Writeback:
  - If `cdb_valid` and entry[cdb_tag-1] is valid and not squashed this cycle, set complete and store `cdb_value`.
  - `valid_wb` is combinational from the same condition. `rd_wb` is the stored rd.
  - A CDB hit on an invalid entry, or `cdb_tag`==0, is dropped, and `valid_wb`=0.
- Commit:
  - `commit` = entry[head].valid && entry[head].complete, combinational.
  - On commit: clear the entry, advance head, decrement count.
  - At most one commit per cycle. If the entry is a branch that is still pending, commit is held until it resolves.
- Branch resolution:
  - On `branch_determined`, clear the branch-pending flag.
  - If `branch_misprediction` is also asserted, invalidate every entry strictly younger than `branch_tag` and set tail = index(branch_tag)+1. Recompute count from head and tail, accounting for a commit in the same cycle.
  - At most one unresolved branch exists at a time. Dispatching a second branch while `branch_speculating`=1 is a protocol violation and is not checked.
- Simultaneous events, highest priority first:
  - Misprediction squash beats dispatch: dispatch is dropped and tail is not advanced.
  - Squash beats a CDB write to a squashed entry.
  - Commit and dispatch together: count is unchanged.
  - Commit and squash together: both take effect.
- Wrap-around: indices wrap ROB_SIZE-1 → 0, so tags wrap ROB_SIZE → 1 and never produce 0.

## Timing
- Reset values: all entries invalid, head = tail = count = 0.
  - `rob_entry_out`=1.
  - `rob_full`=0, `commit`=0, `valid_wb`=0, `branch_speculating`=0.
  - `rd_commit`=0, `rob_entry_commit`=0, `commit_value`=0, `rd_wb`=0.
- Reset mid-operation discards all entries on that edge. No commit is asserted in the reset cycle.
- Dispatch in cycle n: the entry is live from n+1. `rob_entry_out` and `rob_full` update at n+1.
- CDB in cycle n: `valid_wb` in cycle n. The earliest `commit` of that entry is n+1.
- Squash in cycle n: `rob_entry_out` = branch_tag+1 at n+1.

## Structure
- Shared package `sys_defs`:
  - `ROB_SIZE` and `ROB_TAG_LEN` macros.
  - `ZERO_REG`.
  - `ROB_ENTRY` struct: valid, complete, is_branch, rd[4:0], value[31:0].
- Single module. No sub-module is warranted; the pointer arithmetic is inline.

## Test plan
- Reset, then 8 dispatches with no writebacks → tags 1..8 issued, `rob_full`=1 after the 8th. A 9th `dispatch_en` is ignored and `rob_entry_out` stays 1.
- Dispatch rd=5 (tag 1). CDB tag 1, value 0xDEAD → `valid_wb`=1, `rd_wb`=5 same cycle. Next cycle `commit`=1, `rd_commit`=5, `commit_value`=0xDEAD.
- Out-of-order completion: tags 1,2,3 dispatched, CDB order 3,2,1 → commits occur in order 1,2,3 on consecutive cycles after tag 1 completes.
- Branch at tag 2 with tags 3..5 younger; mispredict on tag 2 → tags 3..5 invalid, `rob_entry_out`=3, `branch_speculating`=0. A later CDB on tag 4 gives `valid_wb`=0.
- Full ROB with head complete, commit and `dispatch_en` in the same cycle → dispatch refused, count becomes 7, next cycle dispatch accepted with tag 1 (wrap).
- Assert reset (0) with 4 live entries → next cycle everything is at reset values and `rob_entry_out`=1.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: default sizing, the zero register
// and the per-entry record kept for every in-flight instruction.
package sys_defs;

   localparam int ROB_SIZE    = 8;
   localparam int ROB_TAG_LEN = $clog2(ROB_SIZE) + 1;

   localparam logic [4:0] ZERO_REG = 5'd0;

   typedef struct packed {
      logic        valid;
      logic        complete;
      logic        is_branch;
      logic [4:0]  rd;
      logic [31:0] value;
   } ROB_ENTRY;

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags at dispatch, records CDB results,
// retires in program order and squashes wrong-path entries on a mispredict.
module reorder_buffer
   import sys_defs::ROB_ENTRY, sys_defs::ZERO_REG;
#(
   parameter int ROB_SIZE    = sys_defs::ROB_SIZE,
   parameter int ROB_TAG_LEN = $clog2(ROB_SIZE) + 1
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   dispatch_en,
   input  logic [4:0]             dispatch_rd,
   input  logic                   dispatch_is_branch,
   output logic [ROB_TAG_LEN-1:0] rob_entry_out,
   output logic                   rob_full,
   input  logic                   cdb_valid,
   input  logic [ROB_TAG_LEN-1:0] cdb_tag,
   input  logic [31:0]            cdb_value,
   output logic                   valid_wb,
   output logic [4:0]             rd_wb,
   output logic [ROB_TAG_LEN-1:0] rob_entry_wb,
   output logic                   commit,
   output logic [4:0]             rd_commit,
   output logic [ROB_TAG_LEN-1:0] rob_entry_commit,
   output logic [31:0]            commit_value,
   input  logic                   branch_determined,
   input  logic                   branch_misprediction,
   input  logic [ROB_TAG_LEN-1:0] branch_tag,
   output logic                   branch_speculating
);

   localparam int IDX_W = $clog2(ROB_SIZE);
   localparam int CNT_W = IDX_W + 1;

   ROB_ENTRY             rob [ROB_SIZE];
   logic [IDX_W-1:0]     head;
   logic [IDX_W-1:0]     tail;
   logic [CNT_W-1:0]     count;
   logic                 branch_pending;

   logic [IDX_W-1:0]     cdb_idx;
   logic [IDX_W-1:0]     br_idx;
   logic [IDX_W-1:0]     br_off;
   logic                 cdb_tag_ok;
   logic                 br_tag_ok;
   logic                 squash;
   logic [ROB_SIZE-1:0]  kill_mask;
   logic                 wb_hit;
   logic                 commit_ok;
   logic                 dispatch_ok;
   ROB_ENTRY             head_entry;
   ROB_ENTRY             wb_entry;

   // Tag decoding and the squash window. Age is measured as the distance from
   // head, so "strictly younger than the branch" is a plain offset comparison.
   always_comb begin
      cdb_idx    = cdb_tag[IDX_W-1:0] - IDX_W'(1);
      br_idx     = branch_tag[IDX_W-1:0] - IDX_W'(1);
      br_off     = br_idx - head;
      cdb_tag_ok = (cdb_tag != '0) && (cdb_tag <= ROB_TAG_LEN'(ROB_SIZE));
      br_tag_ok  = (branch_tag != '0) && (branch_tag <= ROB_TAG_LEN'(ROB_SIZE));
      squash     = reset && branch_determined && branch_misprediction && br_tag_ok;
      kill_mask  = '0;
      for (int i = 0; i < ROB_SIZE; i++) begin
         kill_mask[i] = squash && ((IDX_W'(i) - head) > br_off);
      end
   end

   // Writeback, commit and dispatch qualification. The reset term keeps commit
   // and writeback quiet during the cycle in which state is being discarded.
   always_comb begin
      head_entry  = rob[head];
      wb_entry    = rob[cdb_idx];
      wb_hit      = reset && cdb_valid && cdb_tag_ok && wb_entry.valid && !kill_mask[cdb_idx];
      commit_ok   = reset && head_entry.valid && head_entry.complete && !head_entry.is_branch;
      dispatch_ok = reset && dispatch_en && !rob_full && !squash;
   end

   // Entry array. Later assignments win, so commit clears over a late CDB
   // write and the squash mask already excludes any entry a CDB would hit.
   always_ff @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < ROB_SIZE; i++) begin
            rob[i] <= '0;
         end
      end else begin
         if (wb_hit) begin
            rob[cdb_idx].complete <= 1'b1;
            rob[cdb_idx].value    <= cdb_value;
         end
         if (branch_determined && br_tag_ok) begin
            rob[br_idx].is_branch <= 1'b0;
         end
         for (int i = 0; i < ROB_SIZE; i++) begin
            if (kill_mask[i]) begin
               rob[i] <= '0;
            end
         end
         if (commit_ok) begin
            rob[head] <= '0;
         end
         if (dispatch_ok) begin
            rob[tail] <= '{valid: 1'b1, complete: 1'b0, is_branch: dispatch_is_branch,
                           rd: dispatch_rd, value: 32'd0};
         end
      end
   end

   // Pointers and occupancy. After a squash the surviving span runs from head
   // through the branch, less the entry retiring in the same cycle.
   always_ff @(posedge clock) begin
      if (!reset) begin
         head           <= '0;
         tail           <= '0;
         count          <= '0;
         branch_pending <= 1'b0;
      end else begin
         head <= head + IDX_W'(commit_ok);
         if (squash) begin
            tail  <= br_idx + IDX_W'(1);
            count <= CNT_W'(br_off) + CNT_W'(1) - CNT_W'(commit_ok);
         end else begin
            tail  <= tail + IDX_W'(dispatch_ok);
            count <= count + CNT_W'(dispatch_ok) - CNT_W'(commit_ok);
         end
         if (branch_determined) begin
            branch_pending <= 1'b0;
         end
         if (dispatch_ok && dispatch_is_branch) begin
            branch_pending <= 1'b1;
         end
      end
   end

   // Output drive; payload outputs read zero whenever their strobe is low.
   always_comb begin
      rob_entry_out      = ROB_TAG_LEN'(tail) + ROB_TAG_LEN'(1);
      rob_full           = (count == CNT_W'(ROB_SIZE));
      branch_speculating = branch_pending;
      valid_wb           = wb_hit;
      rd_wb              = wb_hit ? wb_entry.rd : ZERO_REG;
      rob_entry_wb       = cdb_tag;
      commit             = commit_ok;
      rd_commit          = commit_ok ? head_entry.rd : ZERO_REG;
      rob_entry_commit   = commit_ok ? (ROB_TAG_LEN'(head) + ROB_TAG_LEN'(1)) : '0;
      commit_value       = commit_ok ? head_entry.value : 32'd0;
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus random traffic, all checked
// every cycle against a program-order queue model of the buffer.
module tb_reorder_buffer;

   localparam int N  = 8;
   localparam int TW = 4;

   logic          clock = 1'b0;
   logic          reset;
   logic          dispatch_en;
   logic [4:0]    dispatch_rd;
   logic          dispatch_is_branch;
   logic [TW-1:0] rob_entry_out;
   logic          rob_full;
   logic          cdb_valid;
   logic [TW-1:0] cdb_tag;
   logic [31:0]   cdb_value;
   logic          valid_wb;
   logic [4:0]    rd_wb;
   logic [TW-1:0] rob_entry_wb;
   logic          commit;
   logic [4:0]    rd_commit;
   logic [TW-1:0] rob_entry_commit;
   logic [31:0]   commit_value;
   logic          branch_determined;
   logic          branch_misprediction;
   logic [TW-1:0] branch_tag;
   logic          branch_speculating;

   reorder_buffer #(.ROB_SIZE(N), .ROB_TAG_LEN(TW)) dut (
      .clock(clock), .reset(reset),
      .dispatch_en(dispatch_en), .dispatch_rd(dispatch_rd),
      .dispatch_is_branch(dispatch_is_branch),
      .rob_entry_out(rob_entry_out), .rob_full(rob_full),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .valid_wb(valid_wb), .rd_wb(rd_wb), .rob_entry_wb(rob_entry_wb),
      .commit(commit), .rd_commit(rd_commit), .rob_entry_commit(rob_entry_commit),
      .commit_value(commit_value),
      .branch_determined(branch_determined), .branch_misprediction(branch_misprediction),
      .branch_tag(branch_tag), .branch_speculating(branch_speculating)
   );

   always #5 clock = ~clock;

   typedef struct {
      int          tag;
      logic [4:0]  rd;
      bit          done;
      logic [31:0] value;
      bit          br;
   } mEntry;

   mEntry q[$];
   int    nextTag;
   bit    pend;
   int    checks;
   int    passes;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) passes++;
      else $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
   endtask

   // One clock of stimulus: drive on the falling edge, compare the model's
   // view of the current cycle, then advance the model across the rising edge.
   task automatic applyStimulus(input bit rst, input bit den, input logic [4:0] drd, input bit dbr,
                                input bit cv, input logic [TW-1:0] ct, input logic [31:0] cval,
                                input bit bd, input bit bm, input logic [TW-1:0] bt);
      int  sz, bp, wp;
      bit  mis, expFull, expCommit, expWb;
      @(negedge clock);
      reset = rst; dispatch_en = den; dispatch_rd = drd; dispatch_is_branch = dbr;
      cdb_valid = cv; cdb_tag = ct; cdb_value = cval;
      branch_determined = bd; branch_misprediction = bm; branch_tag = bt;
      #1;
      sz = q.size();
      bp = -1; wp = -1;
      for (int i = 0; i < sz; i++) begin
         if (q[i].tag == int'(bt)) bp = i;
         if (q[i].tag == int'(ct)) wp = i;
      end
      mis       = rst && bd && bm && (bp >= 0);
      expFull   = (sz == N);
      expCommit = rst && (sz > 0) && q[0].done && !q[0].br;
      expWb     = rst && cv && (wp >= 0) && !(mis && wp > bp);
      checkOutput("rob_full", rob_full, expFull);
      checkOutput("rob_entry_out", rob_entry_out, nextTag);
      checkOutput("branch_speculating", branch_speculating, pend);
      checkOutput("valid_wb", valid_wb, expWb);
      checkOutput("rd_wb", rd_wb, expWb ? q[wp].rd : 5'd0);
      checkOutput("rob_entry_wb", rob_entry_wb, ct);
      checkOutput("commit", commit, expCommit);
      checkOutput("rd_commit", rd_commit, expCommit ? q[0].rd : 5'd0);
      checkOutput("rob_entry_commit", rob_entry_commit, expCommit ? q[0].tag : 0);
      checkOutput("commit_value", commit_value, expCommit ? q[0].value : 32'd0);
      @(posedge clock);
      if (!rst) begin
         q.delete(); nextTag = 1; pend = 0;
      end else begin
         if (expWb) begin
            q[wp].done  = 1;
            q[wp].value = cval;
         end
         if (bd && bp >= 0) q[bp].br = 0;
         if (mis) begin
            while (q.size() > bp + 1) void'(q.pop_back());
            nextTag = int'(bt) % N + 1;
         end
         if (expCommit) void'(q.pop_front());
         if (bd) pend = 0;
         if (den && !expFull && !mis) begin
            q.push_back('{tag: nextTag, rd: drd, done: 0, value: 32'd0, br: dbr});
            nextTag = nextTag % N + 1;
            if (dbr) pend = 1;
         end
      end
   endtask

   task automatic idle();
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic doReset();
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      logic [TW-1:0] ct, bt;
      bit den, dbr, cv, bd, bm;
      checks = 0; passes = 0;
      q.delete(); nextTag = 1; pend = 0;
      reset = 0; dispatch_en = 0; dispatch_rd = 0; dispatch_is_branch = 0;
      cdb_valid = 0; cdb_tag = 0; cdb_value = 0;
      branch_determined = 0; branch_misprediction = 0; branch_tag = 0;
      doReset();
      doReset();

      // Fill to capacity; the ninth request must be ignored.
      for (int i = 1; i <= 9; i++) applyStimulus(1, 1, 5'(i), 0, 0, 0, 0, 0, 0, 0);
      #1;
      checkOutput("fullAfterNine", rob_full, 1'b1);
      checkOutput("tagAfterNine", rob_entry_out, 4'd1);

      // Single writeback then commit.
      doReset();
      applyStimulus(1, 1, 5'd5, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 1, 4'd1, 32'hDEAD, 0, 0, 0);
      #1;
      checkOutput("commitAfterWb", commit, 1'b1);
      checkOutput("commitValueDead", commit_value, 32'hDEAD);
      idle();

      // Out-of-order completion retires in order.
      doReset();
      for (int i = 0; i < 3; i++) applyStimulus(1, 1, 5'(i + 10), 0, 0, 0, 0, 0, 0, 0);
      for (int i = 3; i >= 1; i--) applyStimulus(1, 0, 0, 0, 1, 4'(i), 32'(i * 7), 0, 0, 0);
      for (int i = 0; i < 3; i++) idle();

      // Mispredicted branch at tag 2 squashes tags 3..5.
      doReset();
      for (int i = 1; i <= 5; i++) applyStimulus(1, 1, 5'(i), (i == 2), 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 1, 5'd9, 0, 0, 0, 0, 1, 1, 4'd2);
      #1;
      checkOutput("tagAfterSquash", rob_entry_out, 4'd3);
      checkOutput("specAfterSquash", branch_speculating, 1'b0);
      applyStimulus(1, 0, 0, 0, 1, 4'd4, 32'h44, 0, 0, 0);

      // Full buffer: commit and dispatch together, then a wrapped allocation.
      doReset();
      for (int i = 1; i <= 8; i++) applyStimulus(1, 1, 5'(i), 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 0, 0, 1, 4'd1, 32'h11, 0, 0, 0);
      applyStimulus(1, 1, 5'd20, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(1, 1, 5'd21, 0, 0, 0, 0, 0, 0, 0);
      #1;
      checkOutput("wrapTag", rob_entry_out, 4'd2);

      // Reset with live entries.
      for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 0, 1, 4'(i + 2), 32'h5, 0, 0, 0);
      doReset();
      #1;
      checkOutput("tagAfterReset", rob_entry_out, 4'd1);

      // Random traffic respecting the single-outstanding-branch protocol.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         den = ($urandom_range(0, 9) < 6);
         dbr = !pend && ($urandom_range(0, 4) == 0);
         cv  = ($urandom_range(0, 9) < 6);
         if (q.size() > 0 && $urandom_range(0, 4) != 0)
            ct = TW'(q[$urandom_range(0, q.size() - 1)].tag);
         else
            ct = TW'($urandom_range(0, 15));
         bd = 0; bm = 0; bt = TW'($urandom_range(0, 15));
         if (pend && $urandom_range(0, 3) == 0) begin
            for (int i = 0; i < q.size(); i++) begin
               if (q[i].br) begin
                  bd = 1;
                  bt = TW'(q[i].tag);
               end
            end
            bm = bd && ($urandom_range(0, 1) == 1);
         end
         applyStimulus(($urandom_range(0, 199) != 0), den, 5'($urandom_range(0, 31)), dbr,
                       cv, ct, $urandom, bd, bm, bt);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
